// File: rtl/vga_pkg.sv
// Shared constants, colour-mode enum and colour expansion helper for the VGA frame engine.
package vga_pkg;

    // Default 640x480 @ 60 Hz timing (25 MHz pixel clock)
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned SCALE_DEF    = 2;
    localparam int unsigned ADDR_W_DEF   = 18;
    localparam int unsigned RD_LAT_DEF   = 2;

    typedef enum logic {
        MODE_GRAY   = 1'b0,
        MODE_RGB332 = 1'b1
    } mode_e;

    // Widen {r[2:0],g[2:0],b[1:0]} to 8 bits per channel by bit replication
    function automatic logic [23:0] expand_rgb332(input logic [7:0] px);
        logic [7:0] r8;
        logic [7:0] g8;
        logic [7:0] b8;
        r8 = {px[7:5], px[7:5], px[7:6]};
        g8 = {px[4:2], px[4:2], px[4:3]};
        b8 = {4{px[1:0]}};
        return {r8, g8, b8};
    endfunction

endpackage

// File: rtl/vga_frame_engine_if.sv
// Bundle of control, frame-buffer and DAC-side signals of the VGA frame engine.
interface vga_frame_engine_if #(
    parameter int unsigned ADDR_W = 18
);
    logic [ADDR_W-1:0] fb_base_a;
    logic [ADDR_W-1:0] fb_base_b;
    logic              swap_req;
    logic              mode;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_data;
    logic [7:0]        vga_r;
    logic [7:0]        vga_g;
    logic [7:0]        vga_b;
    logic              vga_hs;
    logic              vga_vs;
    logic              vga_blank_n;
    logic              vga_sync_n;
    logic              frame_start;
    logic              buf_active;

    // Engine side
    modport master (
        input  fb_base_a, fb_base_b, swap_req, mode, mem_data,
        output mem_addr, mem_rd_en, vga_r, vga_g, vga_b, vga_hs, vga_vs,
               vga_blank_n, vga_sync_n, frame_start, buf_active
    );

    // System / memory / DAC side
    modport slave (
        output fb_base_a, fb_base_b, swap_req, mode, mem_data,
        input  mem_addr, mem_rd_en, vga_r, vga_g, vga_b, vga_hs, vga_vs,
               vga_blank_n, vga_sync_n, frame_start, buf_active
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical scan counters with raw (undelayed) sync, active and frame markers.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic clk,
    input  logic rst,
    output logic adv_o,          // counters advance on this clock
    output logic active_o,
    output logic hs_raw_o,
    output logic vs_raw_o,
    output logic frame_start_o,
    output logic line_end_o,
    output logic frame_end_o,
    output logic first_line_o
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    // Low for the first clock after reset so h=0,v=0 is held for one full clock
    logic          run_q;
    logic          line_end;
    logic          last_line;

    // Counter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            run_q <= 1'b1;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Next-state counters and decoded timing flags
    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        last_line = (v_q == VW'(V_TOTAL - 1));
        line_end  = run_q && (h_q == HW'(H_TOTAL - 1));
        if (run_q) begin
            if (line_end) begin
                h_d = '0;
                v_d = last_line ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end

        adv_o         = run_q;
        active_o      = run_q && (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        hs_raw_o      = !((h_q >= HW'(H_ACTIVE + H_FP)) &&
                          (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
        vs_raw_o      = !((v_q >= VW'(V_ACTIVE + V_FP)) &&
                          (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
        frame_start_o = run_q && (h_q == '0) && (v_q == '0);
        line_end_o    = line_end;
        frame_end_o   = line_end && last_line;
        first_line_o  = (v_q == '0);
    end

endmodule

// File: rtl/vga_frame_engine.sv
// Frame-buffer scan engine: scaled addressing, double-buffer swap, latency-matched sync/colour.
module vga_frame_engine
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned SCALE    = SCALE_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RD_LAT   = RD_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    vga_frame_engine_if.master  bus
);
    localparam int unsigned STRIDE = H_ACTIVE / SCALE;
    localparam int unsigned PIPE   = RD_LAT + 2;

    logic adv, active, hs_raw, vs_raw, frame_start, line_end, frame_end, first_line;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .adv_o         (adv),
        .active_o      (active),
        .hs_raw_o      (hs_raw),
        .vs_raw_o      (vs_raw),
        .frame_start_o (frame_start),
        .line_end_o    (line_end),
        .frame_end_o   (frame_end),
        .first_line_o  (first_line)
    );

    logic              buf_active_q, buf_active_d;
    logic              pending_q, pending_d;
    logic [1:0]        hsub_q, hsub_d;
    logic [1:0]        vsub_q, vsub_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [PIPE-1:0]   hs_pipe_q, hs_pipe_d;
    logic [PIPE-1:0]   vs_pipe_q, vs_pipe_d;
    logic [PIPE-1:0]   blank_pipe_q, blank_pipe_d;
    logic [23:0]       rgb_q, rgb_d;
    logic [ADDR_W-1:0] sel_base;
    logic [ADDR_W-1:0] row_base_eff;
    mode_e             mode_sel;

    // All engine state; reset drops every output to its idle level at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_active_q <= 1'b0;
            pending_q    <= 1'b0;
            hsub_q       <= '0;
            vsub_q       <= '0;
            col_q        <= '0;
            row_base_q   <= '0;
            mem_addr_q   <= '0;
            mem_rd_en_q  <= 1'b0;
            hs_pipe_q    <= '1;
            vs_pipe_q    <= '1;
            blank_pipe_q <= '0;
            rgb_q        <= '0;
        end else begin
            buf_active_q <= buf_active_d;
            pending_q    <= pending_d;
            hsub_q       <= hsub_d;
            vsub_q       <= vsub_d;
            col_q        <= col_d;
            row_base_q   <= row_base_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_en_q  <= mem_rd_en_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
            blank_pipe_q <= blank_pipe_d;
            rgb_q        <= rgb_d;
        end
    end

    // Buffer swap, incremental address generation, sync delay and colour expansion
    always_comb begin
        buf_active_d = buf_active_q;
        pending_d    = pending_q;
        hsub_d       = hsub_q;
        vsub_d       = vsub_q;
        col_d        = col_q;
        row_base_d   = row_base_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_en_d  = 1'b0;
        rgb_d        = '0;
        mode_sel     = mode_e'(bus.mode);

        // A request on the boundary clock itself is honoured at that boundary
        if (frame_end && (pending_q || bus.swap_req)) begin
            buf_active_d = ~buf_active_q;
            pending_d    = 1'b0;
        end else if (bus.swap_req) begin
            pending_d = 1'b1;
        end

        // Line 0 reads the live base directly so a swap lands on the frame's first address
        sel_base     = buf_active_q ? bus.fb_base_b : bus.fb_base_a;
        row_base_eff = first_line ? sel_base : row_base_q;

        if (adv) begin
            if (line_end) begin
                hsub_d = '0;
                col_d  = '0;
                if (frame_end) begin
                    vsub_d     = '0;
                    row_base_d = sel_base;
                end else if (vsub_q == 2'(SCALE - 1)) begin
                    vsub_d     = '0;
                    row_base_d = row_base_eff + ADDR_W'(STRIDE);
                end else begin
                    vsub_d     = vsub_q + 1'b1;
                    row_base_d = row_base_eff;
                end
            end else if (hsub_q == 2'(SCALE - 1)) begin
                hsub_d = '0;
                col_d  = col_q + 1'b1;
            end else begin
                hsub_d = hsub_q + 1'b1;
            end
        end

        if (active) begin
            mem_addr_d  = row_base_eff + col_q;
            mem_rd_en_d = 1'b1;
        end

        hs_pipe_d    = {hs_pipe_q[PIPE-2:0], hs_raw};
        vs_pipe_d    = {vs_pipe_q[PIPE-2:0], vs_raw};
        blank_pipe_d = {blank_pipe_q[PIPE-2:0], active};

        // Stage RD_LAT of the blank pipe lines up with the returning pixel byte
        if (blank_pipe_q[RD_LAT]) begin
            if (mode_sel == MODE_RGB332) begin
                rgb_d = expand_rgb332(bus.mem_data);
            end else begin
                rgb_d = {3{bus.mem_data}};
            end
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.vga_r       = rgb_q[23:16];
    assign bus.vga_g       = rgb_q[15:8];
    assign bus.vga_b       = rgb_q[7:0];
    assign bus.vga_hs      = hs_pipe_q[PIPE-1];
    assign bus.vga_vs      = vs_pipe_q[PIPE-1];
    assign bus.vga_blank_n = blank_pipe_q[PIPE-1];
    assign bus.vga_sync_n  = 1'b0;
    assign bus.frame_start = frame_start;
    assign bus.buf_active  = buf_active_q;

endmodule
